sata_oob_sequencer: RTL and testbench



---
 rtl/sata_oob_sequencer.sv | 103 ++++++++++
 tb/tb_sata_oob_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sata_oob_sequencer.sv
// sata_oob_sequencer: SATA OOB burst/gap generator driving txelecidle, with command handshake and abort
module sata_oob_sequencer #(
    parameter int BURST_LEN = 16,
    parameter int GAP_INIT  = 48,
    parameter int GAP_WAKE  = 16,
    parameter int BURSTS    = 6,
    parameter int TAIL_EN   = 1
) (
    input  logic                             reset,
    input  logic                             clk,
    input  logic                             cmd_valid,
    input  logic                             cmd_type,
    input  logic                             abort,
    input  logic                             oobfinish,
    output logic                             ready,
    output logic                             done,
    output logic                             aborted,
    output logic                             cur_type,
    output logic [$clog2(BURSTS+1)-1:0]      burst_num,
    output logic                             txelecidle
);
    localparam int BLW  = $clog2(BURST_LEN + 1);
    localparam int GMAX = (GAP_INIT > GAP_WAKE) ? GAP_INIT : GAP_WAKE;
    localparam int GW   = $clog2(GMAX + 1);
    localparam int NW   = $clog2(BURSTS + 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BURST_LEN - 1);
    localparam logic [NW-1:0]  BN_LAST = NW'(BURSTS - 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP, TAIL} state_t;

    state_t         state, state_n;
    logic [BLW-1:0] burst_len_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [GW-1:0]  gap_last;
    logic           fin;
    logic           inc;
    logic           active;

    assign ready    = (state == IDLE);
    assign active   = (state != IDLE);
    assign gap_last = cur_type ? GW'(GAP_WAKE - 1) : GW'(GAP_INIT - 1);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state, normal-completion flag and burst advance; abort overrides any transition
    always_comb begin
        state_n = state;
        fin     = 1'b0;
        inc     = 1'b0;
        case (state)
            IDLE:  state_n = cmd_valid ? BURST : IDLE;
            BURST: if (burst_len_cnt == BL_LAST) begin
                if (burst_num == BN_LAST) begin
                    state_n = (TAIL_EN != 0) ? TAIL : IDLE;
                    fin     = (TAIL_EN == 0);
                end else begin
                    state_n = GAP;
                    inc     = 1'b1;
                end
            end
            GAP:   if (gap_cnt == gap_last) state_n = BURST;
            TAIL:  if (gap_cnt == gap_last) begin
                state_n = IDLE;
                fin     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (abort && active) begin
            state_n = IDLE;
            fin     = 1'b0;
            inc     = 1'b0;
        end
    end

    // counters clear on every state change; status pulses and line control are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_len_cnt <= '0;
            gap_cnt       <= '0;
            burst_num     <= '0;
            cur_type      <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            txelecidle    <= 1'b1;
        end else begin
            burst_len_cnt <= (state == BURST && state_n == BURST) ? burst_len_cnt + 1'b1 : '0;
            gap_cnt       <= ((state == GAP || state == TAIL) && state_n == state) ? gap_cnt + 1'b1 : '0;
            done          <= fin;
            aborted       <= abort && active;
            txelecidle    <= ~((state == BURST) | oobfinish);
            if (ready && cmd_valid) begin
                cur_type  <= cmd_type;
                burst_num <= '0;
            end else if (inc) begin
                burst_num <= burst_num + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sata_oob_sequencer.sv
// tb_sata_oob_sequencer: directed table and sequence checks for sata_oob_sequencer
module tb_sata_oob_sequencer;
    logic       reset, clk, cmd_valid, cmd_type, abort, oobfinish, cmd_valid_b;
    logic       ready, done, aborted, cur_type, txelecidle;
    logic [2:0] burst_num;
    logic       ready_b, done_b, aborted_b, cur_type_b, txelecidle_b;
    logic [0:0] burst_num_b;
    int         passed = 0, total = 0;

    sata_oob_sequencer dut (
        .reset(reset), .clk(clk), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .abort(abort), .oobfinish(oobfinish), .ready(ready), .done(done),
        .aborted(aborted), .cur_type(cur_type), .burst_num(burst_num),
        .txelecidle(txelecidle)
    );

    sata_oob_sequencer #(.BURST_LEN(1), .BURSTS(1), .TAIL_EN(0)) dut_b (
        .reset(reset), .clk(clk), .cmd_valid(cmd_valid_b), .cmd_type(1'b0),
        .abort(1'b0), .oobfinish(1'b0), .ready(ready_b), .done(done_b),
        .aborted(aborted_b), .cur_type(cur_type_b), .burst_num(burst_num_b),
        .txelecidle(txelecidle_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic cv, ct, ab, of;
        logic e_ready, e_done, e_aborted, e_txe, e_cur;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic t, input int gap, input bit pokes);
        int p, last;
        p    = 16 + gap;
        last = 6 * 16 + 6 * gap;
        cmd_type  = t;
        cmd_valid = 1'b1;
        chk("seq_ready_c0", int'(ready), 1);
        tick();
        for (int c = 1; c <= last + 2; c++) begin
            cmd_valid = pokes && (c == 5 || c == 100);
            cmd_type  = (pokes && (c == 5 || c == 100)) ? ~t : t;
            chk($sformatf("seq_ready_c%0d", c), int'(ready), (c > last) ? 1 : 0);
            chk($sformatf("seq_done_c%0d", c), int'(done), (c == last + 1) ? 1 : 0);
            chk($sformatf("seq_txe_c%0d", c), int'(txelecidle),
                (c >= 2 && c <= last - gap + 1 && ((c - 2) % p) < 16) ? 0 : 1);
            if (((c - 1) % p) == 7 && c <= last - gap)
                chk($sformatf("seq_burst_num_c%0d", c), int'(burst_num), (c - 1) / p);
            if (c == last + 1) begin
                chk("seq_cur_type", int'(cur_type), int'(t));
                chk("seq_final_burst_num", int'(burst_num), 5);
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[9];
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_type = 1'b0; abort = 1'b0;
        oobfinish = 1'b0; cmd_valid_b = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_cur_type", int'(cur_type), 0);
        chk("rst_burst_num", int'(burst_num), 0);
        chk("rst_txe", int'(txelecidle), 1);

        for (int i = 0; i < 9; i++) begin
            cmd_valid = vecs[i].cv; cmd_type = vecs[i].ct;
            abort = vecs[i].ab; oobfinish = vecs[i].of;
            tick();
            cmd_valid = 1'b0; abort = 1'b0; oobfinish = 1'b0;
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].e_ready));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
            chk($sformatf("vec%0d_aborted", i), int'(aborted), int'(vecs[i].e_aborted));
            chk($sformatf("vec%0d_txe", i), int'(txelecidle), int'(vecs[i].e_txe));
            chk($sformatf("vec%0d_cur_type", i), int'(cur_type), int'(vecs[i].e_cur));
        end
        tick();

        run_seq(1'b0, 48, 1'b0);
        run_seq(1'b1, 16, 1'b1);

        cmd_valid_b = 1'b1;
        tick();
        cmd_valid_b = 1'b0;
        chk("b_c1_ready", int'(ready_b), 0);
        chk("b_c1_txe", int'(txelecidle_b), 1);
        chk("b_c1_done", int'(done_b), 0);
        tick();
        chk("b_c2_ready", int'(ready_b), 1);
        chk("b_c2_done", int'(done_b), 1);
        chk("b_c2_txe", int'(txelecidle_b), 0);
        tick();
        chk("b_c3_done", int'(done_b), 0);
        chk("b_c3_txe", int'(txelecidle_b), 1);

        cmd_type = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 150; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_no_done", int'(done), 0);
        chk("abort_txe", int'(txelecidle), 1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("reaccept_ready", int'(ready), 0);
        chk("reaccept_aborted_clear", int'(aborted), 0);
        chk("reaccept_burst_num", int'(burst_num), 0);
        tick();
        chk("reaccept_txe_low", int'(txelecidle), 0);
        for (int c = 3; c < 30; c++) tick();
        oobfinish = 1'b1;
        tick();
        oobfinish = 1'b0;
        chk("oobfinish_gap_txe", int'(txelecidle), 0);
        tick();
        chk("oobfinish_release_txe", int'(txelecidle), 1);
        for (int c = 32; c < 70; c++) tick();
        chk("midburst_txe_low", int'(txelecidle), 0);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_txe", int'(txelecidle), 1);
        chk("async_rst_ready", int'(ready), 1);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_burst_num", int'(burst_num), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_ready", int'(ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
